// File: rtl/gpif_sink_pkg.sv
// Shared types, default sizing and counter widths for the GPIF sink emulator.
package gpif_sink_pkg;

    typedef enum logic {
        TH_FILLING  = 1'b0,
        TH_DRAINING = 1'b1
    } th_state_t;

    localparam int DEF_BUFFER_WORDS    = 8192;
    localparam int DEF_WATERMARK_WORDS = 6;
    localparam int DEF_DRAIN_CYCLES    = 1024;
    localparam int DEF_READY_DELAY     = 16;

    localparam int DATA_W     = 16;
    localparam int WORD_CNT_W = 32;
    localparam int EVT_CNT_W  = 16;

endpackage

// File: rtl/gpif_sink_emulator_if.sv
// GPIF bus between the FPGA writer (master) and the FX3 sink emulator (slave).
interface gpif_sink_emulator_if;
    import gpif_sink_pkg::*;

    logic [DATA_W-1:0] fx3_databus;
    logic              fx3_nWrite;
    logic              fx3_addressBus;
    logic              fx3_nError;
    logic              fx3_nReady;
    logic              fx3_th0Ready;
    logic              fx3_th1Ready;
    logic              fx3_th0Watermark;
    logic              fx3_th1Watermark;

    modport master (
        output fx3_databus, fx3_nWrite, fx3_addressBus, fx3_nError,
        input  fx3_nReady, fx3_th0Ready, fx3_th1Ready,
        input  fx3_th0Watermark, fx3_th1Watermark
    );

    modport slave (
        input  fx3_databus, fx3_nWrite, fx3_addressBus, fx3_nError,
        output fx3_nReady, fx3_th0Ready, fx3_th1Ready,
        output fx3_th0Watermark, fx3_th1Watermark
    );

endinterface

// File: rtl/gpif_sink_thread.sv
// One FX3 DMA thread: fills a buffer, then spends a fixed time draining it.
module gpif_sink_thread
    import gpif_sink_pkg::*;
#(
    parameter int BUFFER_WORDS    = DEF_BUFFER_WORDS,
    parameter int WATERMARK_WORDS = DEF_WATERMARK_WORDS,
    parameter int DRAIN_CYCLES    = DEF_DRAIN_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr,
    output logic accept,
    output logic overrun,
    output logic th_ready_n,
    output logic th_watermark_n
);

    localparam int FW = $clog2(BUFFER_WORDS + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [FW-1:0] FULL   = FW'(BUFFER_WORDS);
    localparam logic [FW-1:0] WM_LVL = FW'(BUFFER_WORDS - WATERMARK_WORDS);
    localparam logic [DW-1:0] DLOAD  = DW'(DRAIN_CYCLES);

    th_state_t     state;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_nxt;
    logic [DW-1:0] drain;

    assign fill_nxt = fill + 1'b1;
    assign accept   = wr && (state == TH_FILLING);
    assign overrun  = wr && (state == TH_DRAINING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= TH_FILLING;
            fill           <= '0;
            drain          <= '0;
            th_ready_n     <= 1'b0;
            th_watermark_n <= 1'b1;
        end else begin
            unique case (state)
                TH_FILLING: begin
                    if (wr) begin
                        fill <= fill_nxt;
                        if (fill_nxt == FULL) begin
                            state          <= TH_DRAINING;
                            drain          <= DLOAD;
                            th_ready_n     <= 1'b1;
                            th_watermark_n <= 1'b1;
                        end else begin
                            th_watermark_n <= !(fill_nxt >= WM_LVL);
                        end
                    end
                end
                TH_DRAINING: begin
                    // Zero is held for one extra edge before refilling.
                    if (drain == '0) begin
                        state          <= TH_FILLING;
                        fill           <= '0;
                        th_ready_n     <= 1'b0;
                        th_watermark_n <= 1'b1;
                    end else begin
                        drain <= drain - 1'b1;
                    end
                end
                default: state <= TH_FILLING;
            endcase
        end
    end

endmodule

// File: rtl/gpif_sink_emulator.sv
// FX3 GPIF sink model: two DMA threads, a sequence checker and stat counters.
module gpif_sink_emulator
    import gpif_sink_pkg::*;
#(
    parameter int BUFFER_WORDS    = DEF_BUFFER_WORDS,
    parameter int WATERMARK_WORDS = DEF_WATERMARK_WORDS,
    parameter int DRAIN_CYCLES    = DEF_DRAIN_CYCLES,
    parameter int READY_DELAY     = DEF_READY_DELAY
) (
    input  logic                  fx3_clock,
    input  logic                  fx3_nReset,
    gpif_sink_emulator_if.slave   bus,
    input  logic                  checkEnable,
    input  logic [DATA_W-1:0]     checkStep,
    output logic [WORD_CNT_W-1:0] wordCount,
    output logic [EVT_CNT_W-1:0]  mismatchCount,
    output logic [EVT_CNT_W-1:0]  overrunCount,
    output logic                  errorSeen
);

    localparam int RW = $clog2(READY_DELAY + 1);
    localparam logic [RW-1:0] RDY_LAST = RW'(READY_DELAY - 1);

    logic              n_ready_q;
    logic [RW-1:0]     rdy_cnt;
    logic              wr_ok;
    logic              acc0, acc1, ovr0, ovr1;
    logic              accept, overrun;
    logic              seeded;
    logic [DATA_W-1:0] expected;

    assign wr_ok   = !bus.fx3_nWrite && !n_ready_q;
    assign accept  = acc0 | acc1;
    assign overrun = ovr0 | ovr1;
    assign bus.fx3_nReady = n_ready_q;

    gpif_sink_thread #(
        .BUFFER_WORDS    (BUFFER_WORDS),
        .WATERMARK_WORDS (WATERMARK_WORDS),
        .DRAIN_CYCLES    (DRAIN_CYCLES)
    ) u_th0 (
        .clk            (fx3_clock),
        .rst_n          (fx3_nReset),
        .wr             (wr_ok && !bus.fx3_addressBus),
        .accept         (acc0),
        .overrun        (ovr0),
        .th_ready_n     (bus.fx3_th0Ready),
        .th_watermark_n (bus.fx3_th0Watermark)
    );

    gpif_sink_thread #(
        .BUFFER_WORDS    (BUFFER_WORDS),
        .WATERMARK_WORDS (WATERMARK_WORDS),
        .DRAIN_CYCLES    (DRAIN_CYCLES)
    ) u_th1 (
        .clk            (fx3_clock),
        .rst_n          (fx3_nReset),
        .wr             (wr_ok && bus.fx3_addressBus),
        .accept         (acc1),
        .overrun        (ovr1),
        .th_ready_n     (bus.fx3_th1Ready),
        .th_watermark_n (bus.fx3_th1Watermark)
    );

    always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
        if (!fx3_nReset) begin
            n_ready_q <= 1'b1;
            rdy_cnt   <= '0;
        end else if (n_ready_q) begin
            rdy_cnt <= rdy_cnt + 1'b1;
            if (rdy_cnt == RDY_LAST) n_ready_q <= 1'b0;
        end
    end

    always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
        if (!fx3_nReset) begin
            wordCount    <= '0;
            overrunCount <= '0;
            errorSeen    <= 1'b0;
        end else begin
            if (accept && wordCount != '1) wordCount <= wordCount + 1'b1;
            if (overrun && overrunCount != '1) overrunCount <= overrunCount + 1'b1;
            if (!bus.fx3_nError) errorSeen <= 1'b1;
        end
    end

    // Every checked word resynchronises the expected sequence.
    always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
        if (!fx3_nReset) begin
            seeded        <= 1'b0;
            expected      <= '0;
            mismatchCount <= '0;
        end else if (!checkEnable) begin
            seeded <= 1'b0;
        end else if (accept) begin
            if (seeded && bus.fx3_databus != expected && mismatchCount != '1)
                mismatchCount <= mismatchCount + 1'b1;
            expected <= bus.fx3_databus + checkStep;
            seeded   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gpif_sink_emulator.sv
// Directed bench for gpif_sink_emulator with small buffer/drain sizing.
module tb_gpif_sink_emulator;

    logic        fx3_clock = 1'b0;
    logic        fx3_nReset;
    logic        checkEnable;
    logic [15:0] checkStep;
    logic [31:0] wordCount;
    logic [15:0] mismatchCount;
    logic [15:0] overrunCount;
    logic        errorSeen;

    int checks = 0;
    int failures = 0;

    gpif_sink_emulator_if bus();

    gpif_sink_emulator #(
        .BUFFER_WORDS    (16),
        .WATERMARK_WORDS (4),
        .DRAIN_CYCLES    (8),
        .READY_DELAY     (4)
    ) dut (
        .fx3_clock     (fx3_clock),
        .fx3_nReset    (fx3_nReset),
        .bus           (bus),
        .checkEnable   (checkEnable),
        .checkStep     (checkStep),
        .wordCount     (wordCount),
        .mismatchCount (mismatchCount),
        .overrunCount  (overrunCount),
        .errorSeen     (errorSeen)
    );

    always #5 fx3_clock = ~fx3_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge fx3_clock);
        #1;
    endtask

    task automatic wr(input logic a, input logic [15:0] d);
        bus.fx3_nWrite     = 1'b0;
        bus.fx3_addressBus = a;
        bus.fx3_databus    = d;
        step();
        bus.fx3_nWrite = 1'b1;
    endtask

    initial begin
        fx3_nReset         = 1'b0;
        bus.fx3_nWrite     = 1'b1;
        bus.fx3_addressBus = 1'b0;
        bus.fx3_databus    = '0;
        bus.fx3_nError     = 1'b1;
        checkEnable        = 1'b0;
        checkStep          = 16'd1;
        step();
        step();
        chk("rst_nready", bus.fx3_nReady, 1);
        chk("rst_th0rdy", bus.fx3_th0Ready, 0);
        chk("rst_th0wm", bus.fx3_th0Watermark, 1);
        chk("rst_words", wordCount, 0);
        chk("rst_err", errorSeen, 0);

        // Writes during the ready delay are ignored.
        fx3_nReset = 1'b1;
        wr(1'b1, 16'd1);
        chk("nready_e1", bus.fx3_nReady, 1);
        wr(1'b1, 16'd2);
        wr(1'b1, 16'd3);
        chk("nready_e3", bus.fx3_nReady, 1);
        wr(1'b1, 16'd4);
        chk("nready_e4", bus.fx3_nReady, 0);
        chk("early_words", wordCount, 0);

        checkEnable = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wr(1'b0, 16'(99 + i));
            if (i == 11) chk("wm_w11", bus.fx3_th0Watermark, 1);
            if (i == 12) chk("wm_w12", bus.fx3_th0Watermark, 0);
            if (i == 15) chk("rdy_w15", bus.fx3_th0Ready, 0);
        end
        chk("rdy_w16", bus.fx3_th0Ready, 1);
        chk("wm_w16", bus.fx3_th0Watermark, 1);
        chk("words_16", wordCount, 16);

        // Drain edges 1..3 overrun th0, 4..5 write th1.
        wr(1'b0, 16'd900);
        wr(1'b0, 16'd901);
        wr(1'b0, 16'd902);
        chk("overrun3", overrunCount, 3);
        chk("words_ovr", wordCount, 16);
        wr(1'b1, 16'd116);
        wr(1'b1, 16'd117);
        chk("words_th1", wordCount, 18);
        chk("th1rdy", bus.fx3_th1Ready, 0);
        step();
        step();
        step();
        chk("drain_e8", bus.fx3_th0Ready, 1);
        step();
        chk("drain_e9", bus.fx3_th0Ready, 0);
        chk("drain_wm", bus.fx3_th0Watermark, 1);
        chk("mm_none", mismatchCount, 0);

        // Re-seed, then 5,6,7,9,10 gives one mismatch.
        checkEnable = 1'b0;
        step();
        checkEnable = 1'b1;
        wr(1'b1, 16'd5);
        wr(1'b1, 16'd6);
        wr(1'b1, 16'd7);
        chk("mm_w7", mismatchCount, 0);
        wr(1'b1, 16'd9);
        chk("mm_w9", mismatchCount, 1);
        wr(1'b1, 16'd10);
        chk("mm_w10", mismatchCount, 1);
        chk("words_23", wordCount, 23);

        checkEnable = 1'b0;
        wr(1'b1, 16'd50);
        chk("mm_hold", mismatchCount, 1);
        checkEnable = 1'b1;
        wr(1'b1, 16'd200);
        wr(1'b1, 16'd201);
        chk("mm_reseed", mismatchCount, 1);
        chk("words_26", wordCount, 26);

        bus.fx3_nError = 1'b0;
        step();
        bus.fx3_nError = 1'b1;
        chk("err_set", errorSeen, 1);
        step();
        step();
        chk("err_sticky", errorSeen, 1);

        // th1 holds 10 words; 6 more fill it.
        for (int i = 0; i < 6; i++) wr(1'b1, 16'(202 + i));
        chk("th1_drain", bus.fx3_th1Ready, 1);
        chk("words_32", wordCount, 32);
        step();
        step();
        fx3_nReset = 1'b0;
        #1;
        chk("ar_nready", bus.fx3_nReady, 1);
        chk("ar_th1rdy", bus.fx3_th1Ready, 0);
        chk("ar_th1wm", bus.fx3_th1Watermark, 1);
        chk("ar_words", wordCount, 0);
        chk("ar_ovr", overrunCount, 0);
        chk("ar_mm", mismatchCount, 0);
        chk("ar_err", errorSeen, 0);

        // After reset the checker must be unseeded.
        step();
        fx3_nReset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("re_nready", bus.fx3_nReady, 0);
        wr(1'b0, 16'd1000);
        wr(1'b0, 16'd1001);
        chk("re_mm", mismatchCount, 0);
        chk("re_words", wordCount, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
